// File: rtl/rf_writeback_queue.sv
// In-order write-back queue in front of the 32x32 register file write port,
// with youngest-match forwarding of queued results to both read ports.
module rf_writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [4:0]                 wb_dest,
    input  logic [31:0]                wb_data,
    input  logic                       rf_stall,
    output logic [4:0]                 rf_dest,
    output logic [31:0]                rf_data,
    output logic                       rf_ld,
    input  logic [4:0]                 rd_a,
    input  logic [4:0]                 rd_b,
    output logic                       fwd_a_hit,
    output logic                       fwd_b_hit,
    output logic [31:0]                fwd_a_data,
    output logic [31:0]                fwd_b_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    dest_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] head, tail;
    logic          push, pop;

    assign empty    = (count == '0);
    assign wb_ready = (count < FULL);
    assign rf_ld    = !empty && !rf_stall;
    assign pop      = rf_ld;
    assign push     = wb_valid && wb_ready && (wb_dest != 5'd0);
    assign rf_dest  = empty ? 5'd0  : dest_q[head];
    assign rf_data  = empty ? 32'd0 : data_q[head];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            // Full blocks push, empty blocks pop, so head and tail never collide here.
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push) begin
                dest_q[tail]  <= wb_dest;
                data_q[tail]  <= wb_data;
                valid_q[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest value.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid_q[idx] && rd_a != 5'd0 && dest_q[idx] == rd_a) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = data_q[idx];
            end
            if (valid_q[idx] && rd_b != 5'd0 && dest_q[idx] == rd_b) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_rf_writeback_queue;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n, wb_valid, wb_ready, rf_stall, rf_ld;
    logic [4:0]  wb_dest, rf_dest, rd_a, rd_b;
    logic [31:0] wb_data, rf_data, fwd_a_data, fwd_b_data;
    logic        fwd_a_hit, fwd_b_hit, empty;
    logic [2:0]  count;

    rf_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest(wb_dest), .wb_data(wb_data), .rf_stall(rf_stall),
        .rf_dest(rf_dest), .rf_data(rf_data), .rf_ld(rf_ld),
        .rd_a(rd_a), .rd_b(rd_b), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT's write port.
    logic [31:0] tb_rf [32];
    always @(posedge clk) if (rf_ld) tb_rf[rf_dest] <= rf_data;

    typedef struct { logic [4:0] dest; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    logic [31:0] model_rf [32];
    logic [31:0] model_wr;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic rn, input logic v, input logic [4:0] d,
                         input logic [31:0] dat, input logic st,
                         input logic [4:0] ra, input logic [4:0] rb);
        reset_n = rn; wb_valid = v; wb_dest = d; wb_data = dat;
        rf_stall = st; rd_a = ra; rd_b = rb;
        #2;
    endtask

    // Expected outputs straight from queue contents.
    task automatic model_check();
        int sz;
        logic ah, bh;
        logic [31:0] ad, bd;
        sz = mq.size();
        ah = 1'b0; bh = 1'b0; ad = '0; bd = '0;
        for (int i = sz - 1; i >= 0; i--) begin
            if (!ah && rd_a != 5'd0 && mq[i].dest == rd_a) begin ah = 1'b1; ad = mq[i].data; end
            if (!bh && rd_b != 5'd0 && mq[i].dest == rd_b) begin bh = 1'b1; bd = mq[i].data; end
        end
        check("wb_ready", 32'(wb_ready), 32'(sz < DEPTH));
        check("rf_ld",    32'(rf_ld),    32'(sz > 0 && !rf_stall));
        check("rf_dest",  32'(rf_dest),  sz > 0 ? 32'(mq[0].dest) : 32'd0);
        check("rf_data",  rf_data,       sz > 0 ? mq[0].data : 32'd0);
        check("count",    32'(count),    32'(sz));
        check("empty",    32'(empty),    32'(sz == 0));
        check("fwd_a_hit", 32'(fwd_a_hit), 32'(ah));
        check("fwd_a_data", fwd_a_data, ad);
        check("fwd_b_hit", 32'(fwd_b_hit), 32'(bh));
        check("fwd_b_data", fwd_b_data, bd);
    endtask

    task automatic advance();
        logic ld, acc;
        ld  = mq.size() > 0 && !rf_stall;
        acc = wb_valid && mq.size() < DEPTH && wb_dest != 5'd0;
        @(posedge clk); #1;
        if (ld) begin
            model_rf[mq[0].dest] = mq[0].data;
            model_wr[mq[0].dest] = 1'b1;
            void'(mq.pop_front());
        end
        if (!reset_n) mq.delete();
        else if (acc) mq.push_back('{dest: wb_dest, data: wb_data});
    endtask

    typedef struct {
        logic v; logic [4:0] d; logic [31:0] dat; logic st; logic [4:0] ra, rb;
        logic e_rdy, e_ld; logic [4:0] e_dest; logic [31:0] e_data; logic [2:0] e_cnt;
        logic e_ah; logic [31:0] e_ad; logic e_bh; logic [31:0] e_bd;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [31:0] seq_in, seq_out;
        model_wr = '0;
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 32'h11, 3'd1, 1'b1, 32'h11, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 5'd1, 1'b1, 1'b0, 5'd1, 32'h11, 3'd2, 1'b1, 32'h22, 1'b1, 32'h11};
        tbl[7]  = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd1, 32'h11, 3'd3, 1'b1, 32'h33, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 5'd9, 1'b0, 1'b0, 5'd1, 32'h11, 3'd4, 1'b1, 32'h44, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd1, 1'b0, 1'b1, 5'd1, 32'h11, 3'd4, 1'b0, 32'h0, 1'b1, 32'h11};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 32'h22, 3'd3, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h33, 3'd2, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0, 1'b1, 1'b1, 5'd4, 32'h44, 3'd1, 1'b1, 32'h44, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 5'd7, 32'hBBBB0000, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'hAAAA0000, 3'd1, 1'b1, 32'hAAAA0000, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'hAAAA0000, 3'd2, 1'b1, 32'hBBBB0000, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 32'hAAAA0000, 3'd2, 1'b1, 32'hBBBB0000, 1'b1, 32'hBBBB0000};
        tbl[18] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'hBBBB0000, 3'd1, 1'b1, 32'hBBBB0000, 1'b0, 32'h0};
        tbl[19] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};

        // Reset, then confirm reset-state outputs.
        apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        advance();
        advance();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd0);
        model_check();
        advance();

        for (int i = 0; i < 20; i++) begin
            apply(1'b1, tbl[i].v, tbl[i].d, tbl[i].dat, tbl[i].st, tbl[i].ra, tbl[i].rb);
            check($sformatf("v%0d.wb_ready", i), 32'(wb_ready), 32'(tbl[i].e_rdy));
            check($sformatf("v%0d.rf_ld", i), 32'(rf_ld), 32'(tbl[i].e_ld));
            check($sformatf("v%0d.rf_dest", i), 32'(rf_dest), 32'(tbl[i].e_dest));
            check($sformatf("v%0d.rf_data", i), rf_data, tbl[i].e_data);
            check($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            check($sformatf("v%0d.empty", i), 32'(empty), 32'(tbl[i].e_cnt == 3'd0));
            check($sformatf("v%0d.fwd_a_hit", i), 32'(fwd_a_hit), 32'(tbl[i].e_ah));
            check($sformatf("v%0d.fwd_a_data", i), fwd_a_data, tbl[i].e_ad);
            check($sformatf("v%0d.fwd_b_hit", i), 32'(fwd_b_hit), 32'(tbl[i].e_bh));
            check($sformatf("v%0d.fwd_b_data", i), fwd_b_data, tbl[i].e_bd);
            advance();
        end
        check("r7_final", tb_rf[7], 32'hBBBB0000);
        check("r4_final", tb_rf[4], 32'h44);

        // Fill to 3 while stalled, then push+pop together for 10 edges across the wrap.
        seq_in = 32'h100; seq_out = 32'h100;
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1, 5'(k % 7 + 1), seq_in, 1'b1, 5'd0, 5'd0);
            seq_in++;
            advance();
        end
        for (int k = 3; k < 13; k++) begin
            apply(1'b1, 1'b1, 5'(k % 7 + 1), seq_in, 1'b0, 5'(k % 7 + 1), 5'((k + 6) % 7 + 1));
            seq_in++;
            check("wrap.count", 32'(count), 32'd3);
            check("wrap.order", rf_data, seq_out);
            seq_out++;
            model_check();
            advance();
        end

        // Reset with 3 entries queued and a push offered on the same edge.
        apply(1'b0, 1'b1, 5'd5, 32'hCAFE0005, 1'b1, 5'd0, 5'd0);
        advance();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd6);
        check("rst.count", 32'(count), 32'd0);
        check("rst.rf_ld", 32'(rf_ld), 32'd0);
        check("rst.fwd_a_hit", 32'(fwd_a_hit), 32'd0);
        model_check();
        advance();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(99) != 0,
                  $urandom_range(9) < 7,
                  ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(6)),
                  $urandom,
                  $urandom_range(9) < 3,
                  5'($urandom_range(6)),
                  5'($urandom_range(6)));
            model_check();
            advance();
        end
        // Drain so the final register-file comparison covers every queued write.
        for (int n = 0; n < 8; n++) begin
            apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
            model_check();
            advance();
        end
        for (int r = 1; r < 32; r++)
            if (model_wr[r]) check($sformatf("regfile.r%0d", r), tb_rf[r], model_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
